pc_update_seq: RTL and testbench

Registered, parametrised successor to the combinational new-PC selector in the Y86 datapath. It sits between the execute/memory stages and fetch. It holds the architectural PC and selects the next value from icode/Cnd/valC/valM/valP. It also keeps a return-address stack (RAS) that predicts `ret` targets and counts mispredictions, and it latches halt and invalid-instruction status.

---
 rtl/pc_update_seq.sv | 135 +++++++++++++
 tb/tb_pc_update_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_seq.sv
// pc_update_seq: registered next-PC selector for the Y86 datapath with a
// circular return-address stack that predicts ret targets, a saturating
// mispredict counter, and sticky halt / invalid-instruction status.
module pc_update_seq #(
  parameter int          W         = 32,
  parameter int          RAS_DEPTH = 8,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             stall,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [W-1:0]     valC,
  input  logic [W-1:0]     valM,
  input  logic [W-1:0]     valP,
  output logic [W-1:0]     pc,
  output logic [W-1:0]     pred_ret_pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ret_mispredict,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             halted,
  output logic             err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [W-1:0]     ras_mem [RAS_DEPTH];
  logic [W-1:0]     pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    ras_cnt_q, ras_cnt_d;
  logic             ovf_q, ovf_d;
  logic             misp_q, misp_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic             ras_we;
  logic             accept;
  logic             empty_w, full_w;

  // RAS status and prediction are derived from the stack state alone.
  always_comb begin
    empty_w     = (ras_cnt_q == '0);
    full_w      = (ras_cnt_q == CW'(RAS_DEPTH));
    pred_ret_pc = empty_w ? '0 : ras_mem[top_q];
  end

  // Next-state selection: PC mux, RAS push/pop, mispredict detection, status.
  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    ras_cnt_d = ras_cnt_q;
    ovf_d     = ovf_q;
    misp_d    = 1'b0;
    halted_d  = halted_q;
    err_d     = err_q;
    ras_we    = 1'b0;
    accept    = valid_in & ~stall & ~halted_q & ~err_q;
    if (accept) begin
      case (icode)
        4'h0: halted_d = 1'b1;
        4'h7: pc_d = cnd ? valC : valP;
        4'h8: begin
          // Push advances the pointer; when full it lands on the oldest entry.
          pc_d   = valC;
          ras_we = 1'b1;
          top_d  = top_q + PW'(1);
          if (full_w) ovf_d = 1'b1;
          else        ras_cnt_d = ras_cnt_q + CW'(1);
        end
        4'h9: begin
          pc_d = valM;
          if (empty_w) begin
            misp_d = 1'b1;
          end else begin
            misp_d    = (ras_mem[top_q] != valM);
            top_d     = top_q - PW'(1);
            ras_cnt_d = ras_cnt_q - CW'(1);
          end
        end
        4'hC, 4'hD, 4'hE, 4'hF: err_d = 1'b1;
        default: pc_d = valP;
      endcase
    end
    mcnt_d = misp_d ? sat_inc(mcnt_q) : mcnt_q;
  end

  // State registers; reset wins over stall and any in-flight RAS operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      top_q     <= '0;
      ras_cnt_q <= '0;
      ovf_q     <= 1'b0;
      misp_q    <= 1'b0;
      mcnt_q    <= '0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      top_q     <= top_d;
      ras_cnt_q <= ras_cnt_d;
      ovf_q     <= ovf_d;
      misp_q    <= misp_d;
      mcnt_q    <= mcnt_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  // Stack storage holds data only; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (rst_n && ras_we) ras_mem[top_d] <= valP;
  end

  assign pc             = pc_q;
  assign ras_empty      = empty_w;
  assign ras_full       = full_w;
  assign ras_ovf        = ovf_q;
  assign ret_mispredict = misp_q;
  assign mispred_cnt    = mcnt_q;
  assign halted         = halted_q;
  assign err            = err_q;

endmodule

// File: tb/tb_pc_update_seq.sv
// Testbench for pc_update_seq: directed test-plan sequence followed by
// randomized traffic, checked against a queue-based reference model.
module tb_pc_update_seq;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, stall, cnd;
  logic [3:0]  icode;
  logic [31:0] valC, valM, valP;

  logic [31:0] pc, pred_ret_pc;
  logic        ras_empty, ras_full, ras_ovf, ret_mispredict, halted, err;
  logic [15:0] mispred_cnt;

  logic [31:0] s_pc, s_pred;
  logic        s_empty, s_full, s_ovf, s_misp, s_halted, s_err;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  pc_update_seq #(.W(32), .RAS_DEPTH(DEPTH), .RESET_PC(32'h100), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .icode(icode),
    .cnd(cnd), .valC(valC), .valM(valM), .valP(valP), .pc(pc),
    .pred_ret_pc(pred_ret_pc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ret_mispredict(ret_mispredict), .mispred_cnt(mispred_cnt),
    .halted(halted), .err(err));

  pc_update_seq #(.W(32), .RAS_DEPTH(DEPTH), .RESET_PC(32'h100), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .icode(icode),
    .cnd(cnd), .valC(valC), .valM(valM), .valP(valP), .pc(s_pc),
    .pred_ret_pc(s_pred), .ras_empty(s_empty), .ras_full(s_full),
    .ras_ovf(s_ovf), .ret_mispredict(s_misp), .mispred_cnt(s_cnt),
    .halted(s_halted), .err(s_err));

  typedef struct {
    logic [31:0] pc, pred;
    logic        empty, full, ovf, misp, halted, err;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: the RAS is just a queue, newest at the back.
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  bit          m_ovf, m_misp, m_halt, m_err;
  int          m_cnt, m_cnt2;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", tag, name, act, expv);
  endtask

  task automatic model(input bit rn, input bit v, input bit st, input logic [3:0] ic,
                       input bit c, input logic [31:0] vc, input logic [31:0] vm,
                       input logic [31:0] vp);
    logic [31:0] top;
    if (!rn) begin
      m_pc = 32'h100; m_ras.delete(); m_ovf = 0; m_misp = 0;
      m_halt = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    m_misp = 0;
    if (!(v && !st && !m_halt && !m_err)) return;
    if (ic == 4'h0) m_halt = 1;
    else if (ic >= 4'hC) m_err = 1;
    else if (ic == 4'h7) m_pc = c ? vc : vp;
    else if (ic == 4'h8) begin
      m_pc = vc;
      m_ras.push_back(vp);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1;
      end
    end else if (ic == 4'h9) begin
      m_pc = vm;
      if (m_ras.size() == 0) m_misp = 1;
      else begin
        top = m_ras.pop_back();
        m_misp = (top != vm);
      end
    end else m_pc = vp;
    if (m_misp) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after its edge.
  task automatic op(input bit rn, input bit v, input bit st, input logic [3:0] ic,
                    input bit c, input logic [31:0] vc, input logic [31:0] vm,
                    input logic [31:0] vp, input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rn; valid_in = v; stall = st; icode = ic; cnd = c;
    valC = vc; valM = vm; valP = vp;
    model(rn, v, st, ic, c, vc, vm, vp);
    e.pc = m_pc;
    e.pred = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    e.empty = (m_ras.size() == 0);
    e.full = (m_ras.size() == DEPTH);
    e.ovf = m_ovf; e.misp = m_misp; e.halted = m_halt; e.err = m_err;
    e.cnt = 16'(m_cnt); e.cnt2 = 2'(m_cnt2); e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: the design updates every edge, so each negedge has a result to check.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "pc", pc, e.pc);
      chk(e.tag, "pred_ret_pc", pred_ret_pc, e.pred);
      chk(e.tag, "ras_empty", 32'(ras_empty), 32'(e.empty));
      chk(e.tag, "ras_full", 32'(ras_full), 32'(e.full));
      chk(e.tag, "ras_ovf", 32'(ras_ovf), 32'(e.ovf));
      chk(e.tag, "ret_mispredict", 32'(ret_mispredict), 32'(e.misp));
      chk(e.tag, "mispred_cnt", 32'(mispred_cnt), 32'(e.cnt));
      chk(e.tag, "halted", 32'(halted), 32'(e.halted));
      chk(e.tag, "err", 32'(err), 32'(e.err));
      chk(e.tag, "sat_cnt", 32'(s_cnt), 32'(e.cnt2));
      chk(e.tag, "sat_pc", s_pc, e.pc);
      chk(e.tag, "sat_pred", s_pred, e.pred);
      chk(e.tag, "sat_flags",
          {26'd0, s_empty, s_full, s_ovf, s_misp, s_halted, s_err},
          {26'd0, e.empty, e.full, e.ovf, e.misp, e.halted, e.err});
    end
  end

  initial begin
    int r, wait_cyc;
    bit rn, v, st, c;
    logic [3:0]  ic;
    logic [31:0] vm;
    rst_n = 0; valid_in = 0; stall = 0; icode = 0; cnd = 0;
    valC = 0; valM = 0; valP = 0;

    op(0, 0, 0, 4'h1, 0, 0, 0, 0, "reset0");
    op(0, 1, 0, 4'h7, 1, 32'h77, 0, 0, "reset1");
    op(1, 1, 0, 4'h7, 0, 32'h99, 0, 32'h10, "jxx_nt");
    op(1, 1, 0, 4'h7, 1, 32'h40, 0, 32'h11, "jxx_t");
    op(1, 1, 1, 4'h7, 1, 32'h99, 0, 32'h12, "stall");
    op(1, 1, 0, 4'h8, 0, 32'h200, 0, 32'h20, "call");
    op(1, 1, 0, 4'h9, 0, 0, 32'h20, 0, "ret_match");
    op(1, 1, 0, 4'h8, 0, 32'h300, 0, 32'h20, "call2");
    op(1, 1, 0, 4'h9, 0, 0, 32'h55, 0, "ret_miss");
    op(1, 0, 0, 4'h9, 0, 0, 32'h55, 0, "pulse_drop");
    op(1, 1, 0, 4'h9, 0, 0, 32'h66, 0, "ret_empty");
    op(1, 0, 0, 4'h1, 0, 0, 0, 0, "idle");
    for (int i = 1; i <= 9; i++) op(1, 1, 0, 4'h8, 0, 32'h1000 + i, 0, 32'(i), "ovf_call");
    for (int i = 9; i >= 2; i--) op(1, 1, 0, 4'h9, 0, 0, 32'(i), 0, "ovf_ret");
    op(1, 1, 0, 4'h9, 0, 0, 32'h77, 0, "ret_9th");
    op(1, 1, 0, 4'h9, 0, 0, 32'h78, 0, "sat4");
    op(1, 1, 0, 4'h9, 0, 0, 32'h79, 0, "sat5");
    op(1, 1, 0, 4'h0, 0, 0, 0, 32'h123, "halt");
    op(1, 1, 0, 4'h7, 1, 32'h500, 0, 32'h4, "after_halt");
    op(1, 1, 0, 4'h8, 0, 32'h600, 0, 32'h5, "after_halt_call");
    op(0, 1, 1, 4'h8, 0, 32'h600, 0, 32'h5, "reset_mid");
    op(1, 1, 0, 4'hE, 0, 32'h700, 0, 32'h6, "err");
    op(1, 1, 0, 4'h7, 1, 32'h800, 0, 32'h7, "after_err");
    op(0, 0, 0, 4'h0, 0, 0, 0, 0, "reset2");

    for (int n = 0; n < 3000; n++) begin
      rn = (m_halt || m_err) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      c  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 99);
      if (r < 30) ic = 4'h8;
      else if (r < 60) ic = 4'h9;
      else if (r < 75) ic = 4'h7;
      else if (r < 97) begin
        ic = 4'($urandom_range(1, 8));
        if (ic == 4'h7) ic = 4'hA;
        if (ic == 4'h8) ic = 4'hB;
      end else if (r < 99) ic = 4'h0;
      else ic = 4'($urandom_range(12, 15));
      if (m_ras.size() > 0 && $urandom_range(0, 9) < 7) vm = m_ras[m_ras.size()-1];
      else vm = $urandom_range(0, 15);
      op(rn, v, st, ic, c, $urandom, vm, $urandom, "random");
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (sb.size() > 0) chk("drain", "queue_left", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
